fp16_sum_sequencer: RTL and testbench

//  Upstream feeder and result register for the combinational 4-operand FP16 adder (Adder_module).

---
 rtl/fp16_sum_sequencer_if.sv | 57 +++++
 rtl/fp16_sum_sequencer.sv | 134 +++++++++++++
 tb/tb_fp16_sum_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_sum_sequencer_if.sv
// rtl/fp16_sum_sequencer_if.sv - operand stream, adder drive and result port bundle (sticky port under FP16_STICKY_FLAGS_EN)
`ifndef floatControlWidth
`define floatControlWidth 1
`endif

interface fp16_sum_sequencer_if #(
  parameter int CTRL_W = `floatControlWidth
);
  // Operand stream
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              in_neg;
  logic              in_last;
  logic [2:0]        rm_in;
  // Adder drive / return
  logic [15:0]       add_a;
  logic [15:0]       add_b;
  logic [15:0]       add_c;
  logic [15:0]       add_d;
  logic [2:0]        add_subop;
  logic [2:0]        add_rm;
  logic [CTRL_W-1:0] add_ctrl;
  logic [15:0]       add_out;
  logic [4:0]        add_flags;
  // Result port
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic [4:0]        res_flags;
`ifdef FP16_STICKY_FLAGS_EN
  logic              flags_clr;
  logic [4:0]        sticky_flags;
`endif

  // Sequencer side
  modport slave (
`ifdef FP16_STICKY_FLAGS_EN
    input  flags_clr,
    output sticky_flags,
`endif
    input  in_valid, in_data, in_neg, in_last, rm_in, add_out, add_flags, res_ready,
    output in_ready, add_a, add_b, add_c, add_d, add_subop, add_rm, add_ctrl,
    output res_valid, res_data, res_flags
  );

  // Environment side (operand source, adder, result sink)
  modport master (
`ifdef FP16_STICKY_FLAGS_EN
    output flags_clr,
    input  sticky_flags,
`endif
    output in_valid, in_data, in_neg, in_last, rm_in, add_out, add_flags, res_ready,
    input  in_ready, add_a, add_b, add_c, add_d, add_subop, add_rm, add_ctrl,
    input  res_valid, res_data, res_flags
  );
endinterface

// File: rtl/fp16_sum_sequencer.sv
// rtl/fp16_sum_sequencer.sv - 4-operand FP16 adder feeder/result register; optional sticky flags via FP16_STICKY_FLAGS_EN
`ifndef floatControlWidth
`define floatControlWidth 1
`endif

module fp16_sum_sequencer #(
  parameter int                CTRL_W   = `floatControlWidth,
  parameter logic [CTRL_W-1:0] CTRL_VAL = '0,
  parameter logic [2:0]        RM_RESET = 3'b000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp16_sum_sequencer_if.slave  bus
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] slot_q [4];
  logic [15:0] slot_d [4];
  logic [3:0]  neg_q, neg_d;
  logic [2:0]  rm_q, rm_d;
  logic        res_valid_q, res_valid_d;
  logic [15:0] res_data_q, res_data_d;
  logic [4:0]  res_flags_q, res_flags_d;

  // Next-state: collect operands, issue one cycle, hold the result until consumed
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    for (int k = 0; k < 4; k++) slot_d[k] = slot_q[k];
    neg_d       = neg_q;
    rm_d        = rm_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    case (state_q)
      S_COLLECT: begin
        if (bus.in_valid) begin
          slot_d[cnt_q] = bus.in_data;
          neg_d[cnt_q]  = bus.in_neg;
          if (cnt_q == 2'd0) rm_d = bus.rm_in;
          if (cnt_q == 2'd3 || bus.in_last) begin
            // Unused slots must contribute +0 to the sum
            for (int k = 0; k < 4; k++) begin
              if (2'(k) > cnt_q) begin
                slot_d[k] = 16'h0000;
                neg_d[k]  = 1'b0;
              end
            end
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_ISSUE: begin
        res_data_d  = bus.add_out;
        res_flags_d = bus.add_flags;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = 2'd0;
          for (int k = 0; k < 4; k++) slot_d[k] = 16'h0000;
          neg_d       = 4'b0000;
          state_d     = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      cnt_q       <= 2'd0;
      for (int k = 0; k < 4; k++) slot_q[k] <= 16'h0000;
      neg_q       <= 4'b0000;
      rm_q        <= RM_RESET;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'h0000;
      res_flags_q <= 5'b00000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      for (int k = 0; k < 4; k++) slot_q[k] <= slot_d[k];
      neg_q       <= neg_d;
      rm_q        <= rm_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
    end
  end

`ifdef FP16_STICKY_FLAGS_EN
  logic [4:0] sticky_q, sticky_d;

  // Accumulate flags of every issued sum; a clear request overrides the update
  always_comb begin
    sticky_d = sticky_q;
    if (state_q == S_ISSUE) sticky_d = sticky_q | bus.add_flags;
    if (bus.flags_clr)      sticky_d = 5'b00000;
  end

  // Sticky flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 5'b00000;
    else        sticky_q <= sticky_d;
  end

  assign bus.sticky_flags = sticky_q;
`endif

  // Slot 0 negation is a sign flip; slots 1-3 negate through the adder's subOp
  assign bus.in_ready  = (state_q == S_COLLECT);
  assign bus.add_a     = {slot_q[0][15] ^ neg_q[0], slot_q[0][14:0]};
  assign bus.add_b     = slot_q[1];
  assign bus.add_c     = slot_q[2];
  assign bus.add_d     = slot_q[3];
  assign bus.add_subop = {neg_q[1], neg_q[2], neg_q[3]};
  assign bus.add_rm    = rm_q;
  assign bus.add_ctrl  = CTRL_VAL;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;

endmodule

// File: tb/tb_fp16_sum_sequencer.sv
// tb/tb_fp16_sum_sequencer.sv - directed and random groups against a reference model; sticky checks under FP16_STICKY_FLAGS_EN
module tb_fp16_sum_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  fp16_sum_sequencer_if bus ();

  fp16_sum_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the external adder: an arbitrary mixing function so routing errors show up
  function automatic logic [15:0] stub_out(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic [15:0] d,
                                           input logic [2:0] s);
    return a ^ {b[7:0], b[15:8]} ^ (c + 16'h1234) ^ {d[14:0], d[15]} ^ {s, 13'h0000};
  endfunction

  function automatic logic [4:0] stub_flags(input logic [15:0] o);
    return o[4:0] ^ o[15:11];
  endfunction

  assign bus.add_out   = stub_out(bus.add_a, bus.add_b, bus.add_c, bus.add_d, bus.add_subop);
  assign bus.add_flags = stub_flags(bus.add_out);

  logic [15:0] g_data [4];
  logic        g_neg  [4];
  logic [4:0]  sticky_m = 5'b00000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_op(input logic [15:0] d, input logic n, input logic l, input logic [2:0] rm);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_neg   = n;
    bus.in_last  = l;
    bus.rm_in    = rm;
    chk("in_ready_collect", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Sends n operands from g_data/g_neg, then checks issue, result, hold and release
  task automatic do_group(input int n, input logic last4, input logic [2:0] rm, input int hold);
    logic [15:0] ea, eb, ec, ed, eo;
    logic [2:0]  es;
    logic [4:0]  ef;
    logic [15:0] v [4];
    logic        ng [4];
    for (int i = 0; i < 4; i++) begin
      v[i]  = (i < n) ? g_data[i] : 16'h0000;
      ng[i] = (i < n) ? g_neg[i] : 1'b0;
    end
    ea = ng[0] ? (v[0] ^ 16'h8000) : v[0];
    eb = v[1];
    ec = v[2];
    ed = v[3];
    es = {ng[1], ng[2], ng[3]};
    eo = stub_out(ea, eb, ec, ed, es);
    ef = stub_flags(eo);
    for (int i = 0; i < n; i++)
      send_op(g_data[i], g_neg[i], (i == n - 1) ? ((n == 4) ? last4 : 1'b1) : 1'b0,
              (i == 0) ? rm : 3'($urandom));
    // Stray traffic while not collecting must be ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    bus.in_last  = 1'b1;
    chk("issue_add_a", 32'(bus.add_a), 32'(ea));
    chk("issue_add_b", 32'(bus.add_b), 32'(eb));
    chk("issue_add_c", 32'(bus.add_c), 32'(ec));
    chk("issue_add_d", 32'(bus.add_d), 32'(ed));
    chk("issue_subop", 32'(bus.add_subop), 32'(es));
    chk("issue_rm", 32'(bus.add_rm), 32'(rm));
    chk("issue_ctrl", 32'(bus.add_ctrl), 32'd0);
    chk("issue_res_valid", 32'(bus.res_valid), 32'd0);
    chk("issue_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("res_valid_rise", 32'(bus.res_valid), 32'd1);
    chk("res_data", 32'(bus.res_data), 32'(eo));
    chk("res_flags", 32'(bus.res_flags), 32'(ef));
`ifdef FP16_STICKY_FLAGS_EN
    sticky_m = sticky_m | ef;
    chk("sticky_accum", 32'(bus.sticky_flags), 32'(sticky_m));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_data", 32'(bus.res_data), 32'(eo));
      chk("hold_flags", 32'(bus.res_flags), 32'(ef));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("release_valid", 32'(bus.res_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic set4(input logic [15:0] d0, input logic n0, input logic [15:0] d1, input logic n1,
                      input logic [15:0] d2, input logic n2, input logic [15:0] d3, input logic n3);
    g_data[0] = d0; g_neg[0] = n0;
    g_data[1] = d1; g_neg[1] = n1;
    g_data[2] = d2; g_neg[2] = n2;
    g_data[3] = d3; g_neg[3] = n3;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_res_data"}, 32'(bus.res_data), 32'd0);
    chk({tag, "_res_flags"}, 32'(bus.res_flags), 32'd0);
    chk({tag, "_add_a"}, 32'(bus.add_a), 32'd0);
    chk({tag, "_add_d"}, 32'(bus.add_d), 32'd0);
    chk({tag, "_subop"}, 32'(bus.add_subop), 32'd0);
    chk({tag, "_rm"}, 32'(bus.add_rm), 32'd0);
`ifdef FP16_STICKY_FLAGS_EN
    chk({tag, "_sticky"}, 32'(bus.sticky_flags), 32'd0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_neg    = 1'b0;
    bus.in_last   = 1'b0;
    bus.rm_in     = 3'b000;
    bus.res_ready = 1'b0;
`ifdef FP16_STICKY_FLAGS_EN
    bus.flags_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1) mixed negations, four operands with last on the 4th
    set4(16'h3C00, 1'b0, 16'h4000, 1'b1, 16'h4500, 1'b0, 16'h4B00, 1'b1);
    do_group(4, 1'b1, 3'b001, 0);

    // 2) two-operand group, upper slots forced to zero
    set4(16'h3C00, 1'b0, 16'h3C00, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    do_group(2, 1'b0, 3'b010, 1);

    // 3) slot 0 negated by sign flip
    set4(16'h3C00, 1'b1, 16'h3C00, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    do_group(2, 1'b0, 3'b000, 0);

    // 4) long backpressure on the result
    set4(16'h1234, 1'b1, 16'h8001, 1'b1, 16'h7BFF, 1'b1, 16'hC000, 1'b0);
    do_group(4, 1'b0, 3'b100, 5);

    // 5a) reset after two operands discards the partial group
    send_op(16'h4000, 1'b1, 1'b0, 3'b011);
    send_op(16'h4400, 1'b1, 1'b0, 3'b011);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid_group");
    @(posedge clk); #2;
    rst_n = 1'b1;
    sticky_m = 5'b00000;
    @(posedge clk); #1;
    set4(16'h3C00, 1'b0, 16'h3C00, 1'b0, 16'h3C00, 1'b0, 16'h3C00, 1'b0);
    do_group(4, 1'b0, 3'b000, 0);

    // 5b) reset while a result is held discards it
    send_op(16'h5555, 1'b0, 1'b1, 3'b110);
    @(posedge clk); #1;
    chk("prereset_valid", 32'(bus.res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_in_hold");
    @(posedge clk); #2;
    rst_n = 1'b1;
    sticky_m = 5'b00000;
    @(posedge clk); #1;

`ifdef FP16_STICKY_FLAGS_EN
    // 6) sticky accumulate then clear
    set4(16'h7BFF, 1'b0, 16'h7BFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    do_group(2, 1'b0, 3'b000, 0);
    set4(16'h3C00, 1'b0, 16'h3C00, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    do_group(2, 1'b0, 3'b000, 0);
    bus.flags_clr = 1'b1;
    @(posedge clk); #1;
    bus.flags_clr = 1'b0;
    sticky_m = 5'b00000;
    chk("sticky_clear", 32'(bus.sticky_flags), 32'd0);
`endif

    // Random groups
    for (int r = 0; r < 24; r++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) begin
        g_data[i] = 16'($urandom);
        g_neg[i]  = 1'($urandom);
      end
      do_group(n, 1'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
